jtag_ir_gen: RTL

JTAG_IR_GEN -- requirements
Module: jtag_ir_gen

---
 rtl/jtag_pkg.sv | 67 ++++++
 rtl/jtag_ir_decoder.sv | 46 ++++
 rtl/jtag_ir_gen.sv | 107 ++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG instruction definitions: instruction slot indices and 16-bit opcodes,
// plus helpers that truncate opcodes to a given IR length and check them for collisions.
package jtag_pkg;

  typedef enum logic [3:0] {
    IDX_BYPASS         = 4'd0,
    IDX_SAMPLE_PRELOAD = 4'd1,
    IDX_EXTEST         = 4'd2,
    IDX_INTEST         = 4'd3,
    IDX_IDCODE         = 4'd4,
    IDX_CLAMP          = 4'd5,
    IDX_HALT           = 4'd6,
    IDX_STEP           = 4'd7,
    IDX_RESUME         = 4'd8,
    IDX_RESET          = 4'd9
  } inst_idx_e;

  localparam int INST_NUM     = 10;
  localparam int IR_WIDTH_MIN = 4;
  localparam int IR_WIDTH_MAX = 16;

  localparam logic [15:0] OP_EXTEST         = 16'h0000;
  localparam logic [15:0] OP_IDCODE         = 16'h0001;
  localparam logic [15:0] OP_SAMPLE_PRELOAD = 16'h0002;
  localparam logic [15:0] OP_INTEST         = 16'h0003;
  localparam logic [15:0] OP_CLAMP          = 16'h0004;
  localparam logic [15:0] OP_HALT           = 16'h0008;
  localparam logic [15:0] OP_STEP           = 16'h0009;
  localparam logic [15:0] OP_RESUME         = 16'h000A;
  localparam logic [15:0] OP_RESET          = 16'h000B;
  localparam logic [15:0] OP_BYPASS         = 16'hFFFF;

  function automatic logic [15:0] opcode_of(input int idx);
    logic [15:0] op;
    case (idx)
      int'(IDX_BYPASS):         op = OP_BYPASS;
      int'(IDX_SAMPLE_PRELOAD): op = OP_SAMPLE_PRELOAD;
      int'(IDX_EXTEST):         op = OP_EXTEST;
      int'(IDX_INTEST):         op = OP_INTEST;
      int'(IDX_IDCODE):         op = OP_IDCODE;
      int'(IDX_CLAMP):          op = OP_CLAMP;
      int'(IDX_HALT):           op = OP_HALT;
      int'(IDX_STEP):           op = OP_STEP;
      int'(IDX_RESUME):         op = OP_RESUME;
      int'(IDX_RESET):          op = OP_RESET;
      default:                  op = OP_BYPASS;
    endcase
    return op;
  endfunction

  function automatic logic [15:0] width_mask(input int w);
    return 16'hFFFF >> (16 - w);
  endfunction

  // True when any two opcodes become identical after truncation to w bits.
  function automatic logic opcodes_collide(input int w);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < INST_NUM; i++) begin
      for (int j = i + 1; j < INST_NUM; j++) begin
        hit = hit | ((opcode_of(i) & width_mask(w)) == (opcode_of(j) & width_mask(w)));
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/jtag_ir_decoder.sv
// Combinational opcode decoder: raw IR opcode -> one-hot instruction plus an
// "unsupported" flag; anything unknown or outside the instruction bus falls back to BYPASS.
module jtag_ir_decoder
  import jtag_pkg::*;
#(
  parameter int IR_WIDTH   = 5,
  parameter int INST_COUNT = 10
) (
  input  logic [IR_WIDTH-1:0]   opcode,
  output logic [INST_COUNT-1:0] onehot,
  output logic                  invalid
);

  localparam logic [15:0] MASK = width_mask(IR_WIDTH);

  logic [15:0] opcode_ext_s;
  logic        match_s;
  logic [3:0]  idx_s;
  logic [3:0]  sel_s;

  assign opcode_ext_s = 16'(opcode);

  // Opcode lookup and one-hot expansion; all-ones always hits BYPASS so it is never invalid.
  always_comb begin
    match_s = 1'b0;
    idx_s   = 4'd0;
    sel_s   = 4'd0;
    invalid = 1'b0;
    onehot  = '0;
    for (int i = 0; i < INST_NUM; i++) begin
      match_s = match_s | ((opcode_of(i) & MASK) == opcode_ext_s);
      idx_s   = ((opcode_of(i) & MASK) == opcode_ext_s) ? 4'(i) : idx_s;
    end
    if (match_s && (int'(idx_s) < INST_COUNT)) begin
      sel_s   = idx_s;
      invalid = 1'b0;
    end else begin
      sel_s   = 4'(IDX_BYPASS);
      invalid = 1'b1;
    end
    for (int j = 0; j < INST_COUNT; j++) begin
      onehot[j] = (int'(sel_s) == j);
    end
  end

endmodule

// File: rtl/jtag_ir_gen.sv
// JTAG instruction register: capture/shift/update IR path with a registered
// one-hot instruction decode and a sticky flag for unsupported opcodes.
module jtag_ir_gen
  import jtag_pkg::*;
#(
  parameter int IR_WIDTH   = 5,
  parameter int INST_COUNT = 10
) (
  input  logic                  tck,
  input  logic                  tl_reset,
  input  logic                  tdi,
  input  logic                  capture_ir,
  input  logic                  shift_ir,
  input  logic                  update_ir,
  input  logic                  tlr_sync,
  input  logic [IR_WIDTH-4:0]   status_in,
  output logic                  tdo,
  output logic [INST_COUNT-1:0] instructions,
  output logic [IR_WIDTH-1:0]   ir_code,
  output logic                  invalid_seen
);

  if ((IR_WIDTH < IR_WIDTH_MIN) || (IR_WIDTH > IR_WIDTH_MAX)) begin : g_bad_ir_width
    $error("jtag_ir_gen: IR_WIDTH %0d outside 4..16", IR_WIDTH);
  end
  if ((INST_COUNT < 1) || (INST_COUNT > INST_NUM)) begin : g_bad_inst_count
    $error("jtag_ir_gen: INST_COUNT %0d outside 1..10", INST_COUNT);
  end
  if (opcodes_collide(IR_WIDTH)) begin : g_opcode_collision
    $error("jtag_ir_gen: opcodes collide at IR_WIDTH %0d", IR_WIDTH);
  end

  localparam logic [IR_WIDTH-1:0]   IDCODE_CODE = IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0]   SR_RESET    = IR_WIDTH'(3'b001);
  // Narrow instruction buses have no IDCODE slot; BYPASS keeps the bus one-hot.
  localparam int                    IDCODE_SLOT = (INST_COUNT > int'(IDX_IDCODE)) ?
                                                  int'(IDX_IDCODE) : int'(IDX_BYPASS);
  localparam logic [INST_COUNT-1:0] IDCODE_OH   = INST_COUNT'(1'b1) << IDCODE_SLOT;

  logic [IR_WIDTH-1:0]   sr_r, sr_next_s;
  logic [IR_WIDTH-1:0]   ir_code_r, ir_code_next_s;
  logic [INST_COUNT-1:0] inst_r, inst_next_s;
  logic                  invalid_r, invalid_next_s;
  logic [INST_COUNT-1:0] dec_onehot_s;
  logic                  dec_invalid_s;

  jtag_ir_decoder #(
    .IR_WIDTH   (IR_WIDTH),
    .INST_COUNT (INST_COUNT)
  ) u_decoder (
    .opcode  (sr_r),
    .onehot  (dec_onehot_s),
    .invalid (dec_invalid_s)
  );

  // Next-state selection: tlr_sync first, then independent shift-path and update-path actions.
  always_comb begin
    sr_next_s      = sr_r;
    ir_code_next_s = ir_code_r;
    inst_next_s    = inst_r;
    invalid_next_s = invalid_r;
    if (tlr_sync) begin
      sr_next_s      = {status_in, 1'b0, 2'b01};
      ir_code_next_s = IDCODE_CODE;
      inst_next_s    = IDCODE_OH;
      invalid_next_s = 1'b0;
    end else begin
      if (capture_ir) begin
        sr_next_s = {status_in, invalid_r, 2'b01};
      end else if (shift_ir) begin
        sr_next_s = {tdi, sr_r[IR_WIDTH-1:1]};
      end else begin
        sr_next_s = sr_r;
      end
      if (update_ir) begin
        ir_code_next_s = sr_r;
        inst_next_s    = dec_onehot_s;
        invalid_next_s = invalid_r | dec_invalid_s;
      end else begin
        ir_code_next_s = ir_code_r;
        inst_next_s    = inst_r;
        invalid_next_s = invalid_r;
      end
    end
  end

  // IR state registers; reset lands immediately so no partial update survives it.
  always_ff @(posedge tck or posedge tl_reset) begin
    if (tl_reset) begin
      sr_r      <= SR_RESET;
      ir_code_r <= IDCODE_CODE;
      inst_r    <= IDCODE_OH;
      invalid_r <= 1'b0;
    end else begin
      sr_r      <= sr_next_s;
      ir_code_r <= ir_code_next_s;
      inst_r    <= inst_next_s;
      invalid_r <= invalid_next_s;
    end
  end

  assign tdo          = sr_r[0];
  assign ir_code      = ir_code_r;
  assign instructions = inst_r;
  assign invalid_seen = invalid_r;

endmodule
